// File: rtl/heap_loader.sv
// heap_loader: column-serial partial-product heap transmitter; HEAP_LOADER_CHECK_EN adds a product check
module heap_loader #(
  parameter int N = 14,
  parameter int SETTLE = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   in_a,
  input  logic [N-1:0]   in_b,
  output logic [2*N-2:0] src_bits,
  output logic           busy,
  output logic           done,
  input  logic [2*N:0]   dst,
  output logic           chk_err
);
  localparam int CW = $clog2((N > SETTLE ? N : SETTLE) + 1);
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_SETTLE, S_DONE} state_t;
  state_t st, st_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [N-1:0] a_r, b_r;
  logic last, acc;
  assign acc = in_valid && st == S_IDLE;
  assign in_ready = st == S_IDLE;
  assign busy = st != S_IDLE;
  assign done = st == S_DONE;
  always_comb begin
    last = (st == S_SHIFT && cnt == CW'(N - 1)) || (st == S_SETTLE && cnt == CW'(SETTLE - 1));
    st_n = st == S_IDLE ? (acc ? S_SHIFT : S_IDLE) :
           st == S_SHIFT ? (last ? S_SETTLE : S_SHIFT) :
           st == S_SETTLE ? (last ? S_DONE : S_SETTLE) : S_IDLE;
    cnt_n = (st == S_IDLE || last) ? '0 : cnt + CW'(1);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= S_IDLE;
      cnt <= '0;
      a_r <= '0;
      b_r <= '0;
    end else begin
      st <= st_n;
      cnt <= cnt_n;
      if (acc) begin
        a_r <= in_a;
        b_r <= in_b;
      end
    end
  end
  // pads occupy the first N-H cycles of each column, real bits a[B+j]&b[c-B-j] follow
  for (genvar c = 0; c < 2*N-1; c++) begin : g_col
    localparam int H = (c + 1 < 2*N-1-c) ? c + 1 : 2*N-1-c;
    localparam int B = (c < N) ? 0 : c - N + 1;
    logic [H-1:0] hit;
    for (genvar j = 0; j < H; j++) begin : g_pp
      assign hit[j] = cnt == CW'(N - H + j) && a_r[B+j] && b_r[c-B-j];
    end
    assign src_bits[c] = st == S_SHIFT && |hit;
  end
`ifdef HEAP_LOADER_CHECK_EN
  logic [2*N-1:0] p_r;
  logic err_r;
  always_ff @(posedge clk) begin
    if (rst) begin
      p_r <= '0;
      err_r <= 1'b0;
    end else if (acc) begin
      p_r <= (2*N)'(in_a) * (2*N)'(in_b);
      err_r <= 1'b0;
    end else if (st == S_DONE) begin
      err_r <= dst != {1'b0, p_r};
    end
  end
  assign chk_err = err_r;
`else
  logic unused_dst;
  assign unused_dst = ^dst;
  assign chk_err = 1'b0;
`endif
endmodule

// File: tb/tb_heap_loader.sv
// tb_heap_loader: directed vectors with a scoreboard of expected products and done latency
module tb_heap_loader;
  localparam int N = 14;
  localparam int SETTLE = 1;
  localparam int LAT = N + SETTLE + 1;
  typedef struct {logic [2*N:0] p; int t; logic e;} exp_t;
  logic clk = 0, rst = 1, in_valid = 0, in_ready, busy, done, chk_err, bad = 0;
  logic [N-1:0] in_a = '0, in_b = '0;
  logic [2*N-2:0] src_bits;
  logic [2*N:0] dst, dst_m, exp_p = '0;
  logic [N-1:0] colr [2*N-1];
  exp_t q[$];
  int checks = 0, errors = 0, cyc = 0, win = 0;
  logic pend = 0, pend_e = 0;

  heap_loader #(.N(N), .SETTLE(SETTLE)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .src_bits(src_bits), .busy(busy), .done(done), .dst(dst), .chk_err(chk_err)
  );

  always #5 clk = ~clk;

  function automatic int hc(input int c);
    return (c + 1 < 2*N-1-c) ? c + 1 : 2*N-1-c;
  endfunction

  function automatic logic [2*N-2:0] exp_src(input int mode, input int k);
    exp_src = '0;
    for (int c = 0; c < 2*N-1; c++)
      exp_src[c] = (mode == 2) ? (k >= N - hc(c)) : (mode == 1 && c == 0 && k == N-1);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // downstream column shift registers plus an ideal compressor (weighted popcount)
  always_comb begin
    dst_m = '0;
    for (int c = 0; c < 2*N-1; c++)
      for (int j = 0; j < hc(c); j++)
        dst_m = dst_m + ((2*N+1)'(colr[c][j]) << c);
  end
  assign dst = dst_m ^ (2*N+1)'(bad);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      q.delete();
      win <= 0;
    end else begin
      if (win > 0) begin
        for (int c = 0; c < 2*N-1; c++) colr[c] <= {colr[c][N-2:0], src_bits[c]};
        win <= win - 1;
      end
      if (in_valid && in_ready) begin
        q.push_back('{exp_p, cyc, bad});
        win <= N;
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (pend) begin
      chk("chk_err_after_done", chk_err, pend_e);
      pend = 0;
    end
    if (!rst) begin
      if (!busy) chk("idle_src_zero", src_bits, 0);
      if (done) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1 expected no pending operation");
        end else begin
          e = q.pop_front();
          chk("product", dst_m, e.p);
          chk("done_latency", cyc, e.t + LAT);
          pend = 1;
          pend_e = e.e;
        end
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("ready_timeout", in_ready, 1);
  endtask

  task automatic send(input logic [N-1:0] a, input logic [N-1:0] b, input logic [2*N:0] p, input int mode);
    in_a = a;
    in_b = b;
    exp_p = p;
    in_valid = 1;
    wait_ready();
    @(negedge clk);
    in_valid = 0;
    in_a = ~a;
    in_b = ~b;
    chk("chk_err_clear_on_accept", chk_err, 0);
    for (int k = 0; k < N; k++) begin
      chk("busy_in_shift", busy, 1);
      if (mode != 3) chk($sformatf("src_bits_k%0d", k), src_bits, exp_src(mode, k));
      @(negedge clk);
    end
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_src", src_bits, 0);
    chk("rst_chk_err", chk_err, 0);
    rst = 0;
    @(negedge clk);
    send(14'd0, 14'd0, 29'd0, 0);
    send(14'd1, 14'd1, 29'h1, 1);
    send(14'h3FFF, 14'h3FFF, 29'h0FFF8001, 2);
    send(14'h3FFF, 14'd1, 29'd16383, 3);
    send(14'h2000, 14'h2000, 29'd67108864, 3);
    // two pairs behind a continuously asserted in_valid
    in_a = 14'd100;
    in_b = 14'd200;
    exp_p = 29'd20000;
    in_valid = 1;
    wait_ready();
    @(negedge clk);
    in_a = 14'h2AAA;
    in_b = 14'h1555;
    exp_p = 29'd59645042;
    n = 1;
    while (!in_ready && n < 40) begin
      chk("busy_while_held", busy, 1);
      @(negedge clk);
      n++;
    end
    chk("second_accept_wait", n, N + SETTLE + 2);
    @(negedge clk);
    in_valid = 0;
    // abort mid-shift, then a clean operation must still be correct
    in_a = 14'h3FFF;
    in_b = 14'h3FFF;
    exp_p = 29'h0FFF8001;
    in_valid = 1;
    wait_ready();
    @(negedge clk);
    in_valid = 0;
    repeat (5) @(negedge clk);
    rst = 1;
    @(negedge clk);
    chk("abort_src", src_bits, 0);
    chk("abort_in_ready", in_ready, 1);
    chk("abort_busy", busy, 0);
    rst = 0;
    repeat (20) @(negedge clk);
    send(14'd123, 14'd456, 29'd56088, 3);
`ifdef HEAP_LOADER_CHECK_EN
    bad = 1;
    send(14'd5, 14'd7, 29'd35, 3);
    repeat (3) @(negedge clk);
    bad = 0;
    send(14'd9, 14'd11, 29'd99, 3);
`endif
    n = 0;
    while ((q.size() != 0 || pend) && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending operations expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
